// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM subsystem: arbiter state encoding and
// the default size of the PSRAM address window.
package psram_pkg;

    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] ARB_GNT0 = 2'b01;
    localparam logic [1:0] ARB_GNT1 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_GNT0 = ARB_GNT0,
        ST_GNT1 = ARB_GNT1
    } arb_state_t;

    // 23-bit word address x 16-bit words = 16 MB of byte address space
    localparam int WIN_WIDTH_DEF = 24;

endpackage

// File: rtl/psram_wbarb.sv
// Two-master Wishbone arbiter for the PSRAM controller: round-robin grant of
// whole cycles, response routing to the owner, local err for out-of-window.
module psram_wbarb
    import psram_pkg::*;
#(
    parameter int win_width = WIN_WIDTH_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    arb_state_t state;
    logic       last;
    logic       err_q;

    logic       m0_oow;
    logic       m1_oow;
    logic       gnt_stb;
    logic       gnt_oow;

    assign m0_oow = |m0_adr_i[31:win_width];
    assign m1_oow = |m1_adr_i[31:win_width];

    // Slave request mux; out-of-window strobes never reach the PSRAM core.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned and no latch is inferred.
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        gnt_stb = 1'b0;
        gnt_oow = 1'b0;
        case (state)
            ST_GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i & ~m0_oow;
                gnt_stb = m0_stb_i;
                gnt_oow = m0_oow;
            end
            ST_GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i & ~m1_oow;
                gnt_stb = m1_stb_i;
                gnt_oow = m1_oow;
            end
            default: ;
        endcase
    end

    // Acks pass straight through to the owner; a stray ack in IDLE is dropped.
    assign m0_ack_o = (state == ST_GNT0) & s_ack_i;
    assign m1_ack_o = (state == ST_GNT1) & s_ack_i;
    assign m0_err_o = (state == ST_GNT0) & err_q;
    assign m1_err_o = (state == ST_GNT1) & err_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            err_q <= gnt_stb & gnt_oow & ~err_q;
            case (state)
                ST_IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= ST_GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= ST_GNT1;
                        last  <= 1'b1;
                    end
                end
                ST_GNT0: if (!m0_cyc_i) state <= ST_IDLE;
                ST_GNT1: if (!m1_cyc_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_wbarb.sv
// Directed self-checking bench for psram_wbarb: grant order, response
// routing, out-of-window errors, cycle locking and asynchronous reset.
module tb_psram_wbarb;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;

    int n_vec;
    int n_miss;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    psram_wbarb dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_dat_o  (m0_dat_o),
        .m0_sel_i  (m0_sel_i),
        .m0_we_i   (m0_we_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_dat_o  (m1_dat_o),
        .m1_sel_i  (m1_sel_i),
        .m1_we_i   (m1_we_i),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i  = '0; s_ack_i = 1'b0;
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        #1;
    endtask

    int g;

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Reset values
        sys_rst_n = 1'b0;
        clear_inputs();
        #2;
        check("rst_s_cyc", s_cyc_o, 1'b0);
        check("rst_s_stb", s_stb_o, 1'b0);
        check("rst_s_we",  s_we_o,  1'b0);
        check("rst_s_adr", s_adr_o, 32'h0);
        check("rst_s_dat", s_dat_o, 32'h0);
        check("rst_s_sel", s_sel_o, 4'h0);
        check("rst_acks",  {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'h0);
        check("rst_m_dat", m0_dat_o | m1_dat_o, 32'h0);
        apply_reset();

        // Single master write
        tick();
        m0_adr_i = 32'h0000_fff0; m0_dat_i = 32'h0001_0203; m0_sel_i = 4'hf;
        m0_we_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        check("wr_idle_cyc", s_cyc_o, 1'b0);
        tick();
        check("wr_s_cyc", s_cyc_o, 1'b1);
        check("wr_s_stb", s_stb_o, 1'b1);
        check("wr_s_adr", s_adr_o, 32'h0000_fff0);
        check("wr_s_dat", s_dat_o, 32'h0001_0203);
        check("wr_s_sel", s_sel_o, 4'hf);
        check("wr_s_we",  s_we_o,  1'b1);
        check("wr_noack", m0_ack_o, 1'b0);
        s_ack_i = 1'b1;
        #1;
        check("wr_m0_ack", m0_ack_o, 1'b1);
        check("wr_m1_ack", m1_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        #1;
        check("wr_drop_cyc", s_cyc_o, 1'b0);
        tick();

        // Simultaneous request straight after reset: m0 first
        apply_reset();
        m0_adr_i = A0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = A1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("tie_gnt0", s_adr_o, A0);
        s_ack_i = 1'b1;
        #1;
        check("tie_ack_m0", {m0_ack_o, m1_ack_o}, 2'b10);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        check("tie_idle_gap", s_cyc_o, 1'b0);
        tick();
        check("tie_gnt1_adr", s_adr_o, A1);
        check("tie_gnt1_cyc", s_cyc_o, 1'b1);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        // Fairness: both masters re-request immediately after every cycle
        m0_adr_i = A0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = A1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g = i % 2;
            tick();
            check("fair_gnt", s_adr_o, (g == 1) ? A1 : A0);
            s_ack_i = 1'b1;
            #1;
            check("fair_ack", {m0_ack_o, m1_ack_o}, (g == 1) ? 2'b01 : 2'b10);
            tick();
            s_ack_i = 1'b0;
            if (g == 1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            else        begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            tick();
            check("fair_idle", s_cyc_o, 1'b0);
            if (g == 1) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
            else        begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        // Out-of-window read by m1, then an in-window read in the same cycle
        m1_adr_i = 32'h0100_0000; m1_we_i = 1'b0; m1_sel_i = 4'hf;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("oow_cyc", s_cyc_o, 1'b1);
        check("oow_stb", s_stb_o, 1'b0);
        check("oow_err_early", m1_err_o, 1'b0);
        tick();
        check("oow_err", m1_err_o, 1'b1);
        check("oow_stb2", s_stb_o, 1'b0);
        check("oow_noack", {m0_ack_o, m1_ack_o, m0_err_o}, 3'b000);
        m1_stb_i = 1'b0;
        tick();
        check("oow_err_clr", m1_err_o, 1'b0);
        m1_adr_i = 32'h0000_fff4; m1_stb_i = 1'b1;
        #1;
        check("rd_stb", s_stb_o, 1'b1);
        check("rd_adr", s_adr_o, 32'h0000_fff4);
        s_ack_i = 1'b1; s_dat_i = 32'h0405_0607;
        #1;
        check("rd_dat", m1_dat_o, 32'h0405_0607);
        check("rd_ack_err", {m1_ack_o, m1_err_o}, 2'b10);
        tick();
        s_ack_i = 1'b0; s_dat_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();

        // Multi-transfer lock: m0 keeps the grant across three strobes
        m0_adr_i = A0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = A1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("lock_adr", s_adr_o, A0);
            check("lock_stb", s_stb_o, 1'b1);
            s_ack_i = 1'b1;
            #1;
            check("lock_ack", {m0_ack_o, m1_ack_o}, 2'b10);
            tick();
            s_ack_i = 1'b0; m0_stb_i = 1'b0;
            #1;
            check("lock_hold", {s_cyc_o, s_stb_o}, 2'b10);
            tick();
            if (k < 2) m0_stb_i = 1'b1;
            #1;
        end
        m0_cyc_i = 1'b0;
        tick();
        check("lock_idle", s_cyc_o, 1'b0);
        tick();
        check("lock_gnt1", s_adr_o, A1);

        // Reset in the middle of an m1 transfer
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        check("mid_pre_stb", s_stb_o, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
        s_ack_i = 1'b1;
        #1;
        check("idle_stray_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        s_ack_i = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        check("post_rst_gnt0", s_adr_o, A0);
        check("post_rst_cyc", s_cyc_o, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/psram_wbarb.md
# psram_wbarb

Two-master Wishbone arbiter in front of the `psram` controller core, letting the CPU data bus (m0) and a DMA/video master (m1) share the single PSRAM slave. It grants whole Wishbone cycles with round-robin fairness. It routes the slave's data and ack back to the granted master only. Accesses outside the PSRAM window are rejected locally with `err` and never reach the slave.

## Interface
Parameters:
- `win_width`, 24: byte-address bits decoded as PSRAM (23-bit word address × 16 bit = 16 MB). `adr_i[31:win_width] != 0` is out of window.

Ports:
- `sys_clk`  in  1  system clock; all state on its rising edge.
- `sys_rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `m0_adr_i`/`m1_adr_i`  in  32  master byte address.
- `m0_dat_i`/`m1_dat_i`  in  32  master write data.
- `m0_dat_o`/`m1_dat_o`  out  32  read data; `s_dat_i` is broadcast to both.
- `m0_sel_i`/`m1_sel_i`  in  4  byte selects.
- `m0_we_i`/`m1_we_i`  in  1  write enable.
- `m0_cyc_i`/`m1_cyc_i`, `m0_stb_i`/`m1_stb_i`  in  1  Wishbone cycle and strobe.
- `m0_ack_o`/`m1_ack_o`  out  1  transfer acknowledge.
- `m0_err_o`/`m1_err_o`  out  1  out-of-window error.
- `s_adr_o`  out  32, `s_dat_o`  out  32, `s_sel_o`  out  4, `s_we_o`/`s_cyc_o`/`s_stb_o`  out  1  slave request to `psram`.
- `s_dat_i`  in  32, `s_ack_i`  in  1  slave response.

## Operation
- FSM states: IDLE, GNT0, GNT1. A registered `last` bit holds the most recently granted master. Reset value of `last` is 1, so m0 wins the first tie.
- **IDLE**: no slave signals asserted.
  - Only `m0_cyc_i` high → GNT0.
  - Only `m1_cyc_i` high → GNT1.
  - Both high → grant the master ≠ `last`.
  - On every grant, `last` is updated to the granted master.
- **GNTx**, master x in window:
  - `s_adr_o`/`s_dat_o`/`s_sel_o`/`s_we_o` = mx inputs (combinational mux on state).
  - `s_cyc_o` = `mx_cyc_i`; `s_stb_o` = `mx_stb_i`.
- **GNTx**, master x out of window: `s_stb_o` is forced 0.
- Ack routing: `mx_ack_o` = `s_ack_i` while in GNTx, else 0. The other master's ack is always 0.
- Error: `err_q` is a register. It sets one cycle after a strobe with an out-of-window address (`mx_stb_i & oow & !err_q`) and clears the next cycle. `mx_err_o` = `err_q` when in GNTx.
- Multiple transfers inside one cycle (cyc held, stb toggled) stay granted. The grant is never preempted.
- `mx_cyc_i` low while in GNTx → IDLE at the next edge. The other master can be granted one cycle later, so there is one idle cycle between owners.
- Slave outputs carry don't-care data when idle but `s_cyc_o`/`s_stb_o` are guaranteed 0.

## Timing
- Reset values: state IDLE, `last`=1, `err_q`=0. All `*_ack_o`, `*_err_o`, `s_cyc_o`, `s_stb_o`, `s_we_o` = 0. `s_adr_o`, `s_dat_o`, `s_sel_o`, `*_dat_o` = 0.
- Reset asserted mid-transfer: `s_cyc_o`/`s_stb_o` drop asynchronously. The psram core is reset by the same reset.
- Grant latency: cyc sampled high in IDLE at edge N → slave sees cyc/stb from edge N (state GNTx after N).
- Arbiter adds zero latency on ack: combinational passthrough of `s_ack_i`.
- Error latency: one cycle after stb. There is never an ack and an err in the same cycle.
- A master dropping cyc in the same cycle as `s_ack_i` is legal. The next cycle is IDLE.
- Slave asserting `s_ack_i` while in IDLE (protocol violation) is ignored, with no ack to either master.

## Structure
- Shared package `psram_pkg` holds:
  - state encoding localparams (`ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`);
  - the default `win_width`.
- No sub-module. Single file; the two-way mux and round-robin are small enough to inline.

## Test plan
- Single master: m0 writes 0x00010203 to 0x0000fff0, sel=1111 → `s_cyc_o` high the edge after `m0_cyc_i`, `m0_ack_o` pulses with `s_ack_i`, `m1_ack_o` stays 0.
- Simultaneous request after reset: m0 and m1 assert cyc in the same cycle → m0 granted first. m1 is granted one idle cycle after m0 drops cyc, and `last`=1.
- Fairness: both masters issue back-to-back cycles continuously → grants alternate m0, m1, m0, m1 over 8 cycles, with no master served twice in a row.
- Out-of-window: m1 reads 0x01000000 → `s_stb_o` stays 0, `m1_err_o` is high exactly one cycle, no ack. A following in-window read of 0x0000fff4 returns slave data 0x04050607.
- Multi-transfer lock: m0 holds cyc and does 3 stb transfers while m1 requests → m1 is not granted until m0 drops cyc.
- Reset mid-transfer: `sys_rst_n` low while in GNT1 with stb high → `s_cyc_o`/`s_stb_o` go 0 immediately. After release, state is IDLE and m0 wins the tie.
